// File: rtl/cop0_regfile_pkg.sv
// cop0_info: CP0 register numbers, field indices, reset values and writable masks.
package cop0_info;
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;
    localparam logic [4:0] REG_LLADDR   = 5'd17;
    localparam logic [4:0] REG_ERROREPC = 5'd30;

    localparam int IDX_STATUS_IE  = 0;
    localparam int IDX_STATUS_EXL = 1;
    localparam int IDX_STATUS_ERL = 2;
    localparam int IDX_STATUS_BEV = 22;
    localparam int IDX_CAUSE_BD   = 31;
    localparam int IDX_CAUSE_TI   = 30;
    localparam int IP_LO = 8, IP_HI = 15;
    localparam int IM_LO = 8, IM_HI = 15;
    localparam int EXC_LO = 2, EXC_HI = 6;

    localparam logic [31:0] STATUS_RESET = 32'h00400004;
    localparam logic [31:0] WMASK_FULL   = 32'hFFFFFFFF;
    localparam logic [31:0] WMASK_CAUSE  = 32'h00000300;
    localparam logic [31:0] WMASK_NONE   = 32'h00000000;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,  EXC_MOD  = 5'd1,  EXC_TLBL = 5'd2,  EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,  EXC_ADES = 5'd5,  EXC_IBE  = 5'd6,  EXC_DBE  = 5'd7,
        EXC_SYS  = 5'd8,  EXC_BP   = 5'd9,  EXC_RI   = 5'd10, EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12, EXC_TR   = 5'd13
    } exc_code_e;

    // BadVAddr, PRId and Config are software read-only; unimplemented numbers ignore writes
    function automatic logic [31:0] wr_mask(input logic [4:0] a);
        case (a)
            REG_COUNT, REG_COMPARE, REG_STATUS, REG_EPC, REG_LLADDR, REG_ERROREPC: return WMASK_FULL;
            REG_CAUSE: return WMASK_CAUSE;
            default:   return WMASK_NONE;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] val, input logic [31:0] m);
        return (old & ~m) | (val & m);
    endfunction
endpackage

// File: rtl/cop0_regfile_if.sv
// cop0_regfile_if: MTC0 write port and MFC0 read port between pipeline and CP0.
interface cop0_regfile_if;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    modport master(output we, waddr, wdata, wmask, raddr, input rdata);
    modport slave(input we, waddr, wdata, wmask, raddr, output rdata);
endinterface

// File: rtl/cop0_regfile_timer.sv
// cop0_timer: Count/Compare timer with prescaler and timer-interrupt flag.
module cop0_timer import cop0_info::*; #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    input  logic [31:0] wmask,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam logic [31:0] DIV_MAX = 32'(COUNT_DIV - 1);
    logic [31:0] div;
    logic        wrap;
    assign wrap = div == DIV_MAX;
    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= merge(count, wdata, wmask);
                div   <= '0;
            end else begin
                div <= wrap ? '0 : div + 32'd1;
                if (wrap) count <= count + 32'd1;
            end
            if (compare_we) compare <= merge(compare, wdata, wmask);
            // a Compare write acknowledges the timer and beats a simultaneous match
            if (compare_we) ti <= 1'b0;
            else if (wrap && !count_we && count + 32'd1 == compare) ti <= 1'b1;
        end
    end
endmodule

// File: rtl/cop0_regfile.sv
// cop0_regfile: architectural CP0 registers, exception capture and interrupt request.
module cop0_regfile import cop0_info::*; #(
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] PRID_VALUE   = 32'h00018000,
    parameter logic [31:0] CONFIG_VALUE = 32'h80000000
) (
    input  logic                 clk,
    input  logic                 reset,
    cop0_regfile_if.slave        bus,
    input  logic [5:0]           hw_int,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          exc_epc,
    input  logic                 exc_bd,
    input  logic                 exc_badvaddr_we,
    input  logic [31:0]          exc_badvaddr,
    output logic [31:0]          status,
    output logic [31:0]          cause,
    output logic [31:0]          epc,
    output logic [31:0]          errorepc,
    output logic                 int_pending
);
    logic [31:0] badvaddr, lladdr, count, compare, cur, wm;
    logic        ti, bd, wr;
    logic [4:0]  exccode;
    logic [1:0]  ip_sw;
    logic [5:0]  ip_hw;

    // an exception in the same cycle drops the whole write, timer side effects included
    assign wr = bus.we & ~exc_valid;
    assign wm = bus.wmask & wr_mask(bus.waddr);

    cop0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk(clk), .reset(reset),
        .count_we(wr && bus.waddr == REG_COUNT),
        .compare_we(wr && bus.waddr == REG_COMPARE),
        .wdata(bus.wdata), .wmask(wm),
        .count(count), .compare(compare), .ti(ti)
    );

    assign cause = {bd, ti, 14'b0, ip_hw[5] | ti, ip_hw[4:0], ip_sw, 1'b0, exccode, 2'b0};
    assign int_pending = status[IDX_STATUS_IE] & ~status[IDX_STATUS_EXL] & ~status[IDX_STATUS_ERL]
                       & |(cause[IP_HI:IP_LO] & status[IM_HI:IM_LO]);

    always_ff @(posedge clk) begin
        if (reset) begin
            status   <= STATUS_RESET;
            epc      <= '0;
            errorepc <= '0;
            badvaddr <= '0;
            lladdr   <= '0;
            bd       <= 1'b0;
            exccode  <= '0;
            ip_sw    <= '0;
            ip_hw    <= '0;
        end else begin
            ip_hw <= hw_int;
            if (exc_valid) begin
                exccode <= exc_code;
                if (!status[IDX_STATUS_EXL]) begin
                    epc <= exc_epc;
                    bd  <= exc_bd;
                end
                status[IDX_STATUS_EXL] <= 1'b1;
                if (exc_badvaddr_we) badvaddr <= exc_badvaddr;
            end else if (bus.we) begin
                case (bus.waddr)
                    REG_STATUS:   status   <= merge(status, bus.wdata, wm);
                    REG_CAUSE:    ip_sw    <= (ip_sw & ~wm[9:8]) | (bus.wdata[9:8] & wm[9:8]);
                    REG_EPC:      epc      <= merge(epc, bus.wdata, wm);
                    REG_LLADDR:   lladdr   <= merge(lladdr, bus.wdata, wm);
                    REG_ERROREPC: errorepc <= merge(errorepc, bus.wdata, wm);
                    default: ;
                endcase
            end
        end
    end

    assign cur = bus.raddr == REG_BADVADDR ? badvaddr :
                 bus.raddr == REG_COUNT    ? count    :
                 bus.raddr == REG_COMPARE  ? compare  :
                 bus.raddr == REG_STATUS   ? status   :
                 bus.raddr == REG_CAUSE    ? cause    :
                 bus.raddr == REG_EPC      ? epc      :
                 bus.raddr == REG_PRID     ? PRID_VALUE :
                 bus.raddr == REG_CONFIG   ? CONFIG_VALUE :
                 bus.raddr == REG_LLADDR   ? lladdr   :
                 bus.raddr == REG_ERROREPC ? errorepc : '0;
    assign bus.rdata = (wr && bus.waddr == bus.raddr)
                     ? merge(cur, bus.wdata, bus.wmask & wr_mask(bus.raddr)) : cur;
endmodule

// File: tb/tb_cop0_regfile.sv
// tb_cop0_regfile: directed test-plan steps plus randomized traffic against an array-based CP0 model.
module tb_cop0_regfile;
    localparam int DIV = 2;
    localparam logic [31:0] PRID = 32'h00018000;
    localparam logic [31:0] CFG  = 32'h80000000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cop0_regfile_if bus();
    logic [5:0]  hw_int;
    logic        exc_valid, exc_bd, exc_badvaddr_we, int_pending;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc, exc_badvaddr, status, cause, epc, errorepc;

    cop0_regfile #(.COUNT_DIV(DIV), .PRID_VALUE(PRID), .CONFIG_VALUE(CFG)) dut (
        .clk(clk), .reset(reset), .bus(bus), .hw_int(hw_int),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
        .exc_badvaddr_we(exc_badvaddr_we), .exc_badvaddr(exc_badvaddr),
        .status(status), .cause(cause), .epc(epc), .errorepc(errorepc), .int_pending(int_pending)
    );

    int n_chk = 0, n_ok = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // model: r[] holds software-visible values; Cause keeps only BD, IP[1:0], ExcCode, the rest is derived
    logic [31:0] r [32];
    logic        m_ti;
    logic [5:0]  m_hw;
    int          m_div;

    function automatic logic [31:0] wmask_of(input logic [4:0] a);
        case (a)
            5'd9, 5'd11, 5'd12, 5'd14, 5'd17, 5'd30: return 32'hFFFFFFFF;
            5'd13: return 32'h00000300;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_cause();
        return r[13] | {1'b0, m_ti, 14'b0, m_hw[5] | m_ti, m_hw[4:0], 10'b0};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        return a == 5'd13 ? m_cause() : a == 5'd15 ? PRID : a == 5'd16 ? CFG : r[a];
    endfunction

    function automatic logic exp_pending();
        logic [31:0] s, c;
        s = r[12];
        c = m_cause();
        return s[0] && !s[1] && !s[2] && |(c[15:8] & s[15:8]);
    endfunction

    function automatic logic [31:0] exp_rdata();
        logic [31:0] m;
        m = bus.wmask & wmask_of(bus.raddr);
        if (bus.we && !exc_valid && bus.waddr == bus.raddr)
            return (m_read(bus.raddr) & ~m) | (bus.wdata & m);
        return m_read(bus.raddr);
    endfunction

    task automatic m_reset();
        foreach (r[i]) r[i] = '0;
        r[12] = 32'h00400004;
        m_ti = 1'b0;
        m_hw = '0;
        m_div = 0;
    endtask

    task automatic m_step();
        logic wr, tiset;
        logic [31:0] m, nv;
        if (reset) begin
            m_reset();
            return;
        end
        wr = bus.we && !exc_valid;
        m = bus.wmask & wmask_of(bus.waddr);
        nv = (m_read(bus.waddr) & ~m) | (bus.wdata & m);
        tiset = 1'b0;
        if (wr && bus.waddr == 5'd9) begin
            r[9] = nv;
            m_div = 0;
        end else begin
            m_div++;
            if (m_div == DIV) begin
                m_div = 0;
                r[9] = r[9] + 32'd1;
                tiset = r[9] == r[11];
            end
        end
        if (wr && bus.waddr == 5'd11) m_ti = 1'b0;
        else if (tiset) m_ti = 1'b1;
        if (wr) begin
            if (bus.waddr == 5'd13) r[13][9:8] = nv[9:8];
            else if (bus.waddr != 5'd9) r[bus.waddr] = nv;
        end
        m_hw = hw_int;
        if (exc_valid) begin
            r[13][6:2] = exc_code;
            if (!r[12][1]) begin
                r[14] = exc_epc;
                r[13][31] = exc_bd;
            end
            r[12][1] = 1'b1;
            if (exc_badvaddr_we) r[8] = exc_badvaddr;
        end
    endtask

    task automatic tick();
        #1;
        chk("status", status, r[12]);
        chk("cause", cause, m_cause());
        chk("epc", epc, r[14]);
        chk("errorepc", errorepc, r[30]);
        chk("rdata", bus.rdata, exp_rdata());
        chk("int_pending", 32'(int_pending), 32'(exp_pending()));
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic idle();
        bus.we = 0; bus.waddr = 0; bus.wdata = 0; bus.wmask = 0; bus.raddr = 0;
        hw_int = 0; exc_valid = 0; exc_code = 0; exc_epc = 0; exc_bd = 0;
        exc_badvaddr_we = 0; exc_badvaddr = 0;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1; bus.waddr = a; bus.wdata = d; bus.wmask = 32'hFFFFFFFF;
        tick();
        bus.we = 0;
    endtask

    logic [4:0] addrs [10] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd30};

    initial begin
        idle();
        reset = 1;
        @(posedge clk);
        m_reset();
        #1;
        tick();
        reset = 0;
        bus.raddr = 15;
        #1;
        chk("rst_status", status, 32'h00400004);
        chk("rst_cause", cause, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_prid", bus.rdata, 32'h00018000);
        chk("rst_irq", 32'(int_pending), 32'h0);

        wr_reg(5'd12, 32'h0000FF01);
        chk("st_wr", status, 32'h0000FF01);
        hw_int = 6'b000001;
        tick();
        chk("ip2", 32'(cause[10]), 32'h1);
        chk("irq_hw", 32'(int_pending), 32'h1);
        hw_int = 0;
        tick();

        wr_reg(5'd9, 32'hFFFFFFFE);
        bus.raddr = 9;
        tick();
        tick();
        chk("cnt2", bus.rdata, 32'hFFFFFFFF);
        tick();
        tick();
        chk("cnt4", bus.rdata, 32'h0);
        chk("ti_set", 32'(cause[30]), 32'h1);
        chk("irq_ti", 32'(int_pending), 32'h1);
        wr_reg(5'd11, 32'h00000100);
        chk("ti_clr", 32'(cause[30]), 32'h0);
        chk("irq_ti_clr", 32'(int_pending), 32'h0);

        exc_valid = 1; exc_code = 4; exc_epc = 32'hBFC00100; exc_bd = 1;
        exc_badvaddr_we = 1; exc_badvaddr = 32'h3;
        tick();
        exc_valid = 0; exc_badvaddr_we = 0;
        bus.raddr = 8;
        #1;
        chk("exc_epc", epc, 32'hBFC00100);
        chk("exc_code", 32'(cause[6:2]), 32'h4);
        chk("exc_bd", 32'(cause[31]), 32'h1);
        chk("exc_exl", 32'(status[1]), 32'h1);
        chk("exc_bva", bus.rdata, 32'h3);
        exc_valid = 1; exc_code = 5; exc_epc = 32'h80000080; exc_bd = 0;
        tick();
        exc_valid = 0;
        chk("exc2_epc", epc, 32'hBFC00100);

        wr_reg(5'd12, 32'h0000FF01);
        bus.we = 1; bus.waddr = 14; bus.wdata = 32'h12345678; bus.wmask = 32'hFFFFFFFF;
        exc_valid = 1; exc_epc = 32'hAAAA0000;
        tick();
        bus.we = 0; exc_valid = 0;
        chk("exc_vs_we", epc, 32'hAAAA0000);

        bus.we = 1; bus.waddr = 13; bus.wdata = 32'hFFFFFFFF; bus.wmask = 32'h0000FF00; bus.raddr = 13;
        #1;
        chk("cause_byp", bus.rdata, m_cause() | 32'h00000300);
        tick();
        bus.we = 0;
        chk("cause_sw", 32'(cause[9:8]), 32'h3);
        tick();

        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 199) == 0;
            bus.we = $urandom_range(0, 2) == 0;
            bus.waddr = $urandom_range(0, 3) == 0 ? 5'($urandom) : addrs[$urandom_range(0, 9)];
            bus.wdata = $urandom;
            if (bus.waddr == 9 && $urandom_range(0, 1) == 1) bus.wdata = r[11] - 32'($urandom_range(0, 3));
            if (bus.waddr == 11 && $urandom_range(0, 1) == 1) bus.wdata = r[9] + 32'($urandom_range(1, 3));
            bus.wmask = $urandom_range(0, 1) == 1 ? 32'hFFFFFFFF : $urandom;
            bus.raddr = $urandom_range(0, 1) == 1 ? bus.waddr : 5'($urandom);
            hw_int = $urandom_range(0, 3) == 0 ? 6'($urandom) : 6'h0;
            exc_valid = $urandom_range(0, 15) == 0;
            exc_code = 5'($urandom);
            exc_epc = $urandom;
            exc_bd = 1'($urandom);
            exc_badvaddr_we = 1'($urandom);
            exc_badvaddr = $urandom;
            tick();
        end
        reset = 0;
        idle();
        tick();
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule

// File: doc/cop0_regfile.md
Name: cop0_regfile

Overview:
- Architectural CP0 register file at the writeback end of the pipeline. Consumes the value and write mask produced by the execute-stage CP0 source mux.
- Performs masked writes and serves MFC0 reads. Runs the Count/Compare timer and samples hardware interrupts into Cause.
- Records exception state (EPC, Cause, BadVAddr, Status.EXL) and raises the interrupt request back into the pipeline.

Parameters:
- COUNT_DIV, 2: clock cycles per Count increment (>=1).
- PRID_VALUE, 32'h00018000: read-only PRId contents.
- CONFIG_VALUE, 32'h80000000: read-only Config contents.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- we  in  1  CP0 write enable from writeback
- waddr  in  5  destination register number (sel 0 only)
- wdata  in  32  write value (execute-stage mux output y)
- wmask  in  32  per-bit write mask (mux output wmask)
- raddr  in  5  MFC0 read register number
- rdata  out  32  read data
- hw_int  in  6  level-sensitive external interrupts
- exc_valid  in  1  exception commit this cycle
- exc_code  in  5  Cause.ExcCode value
- exc_epc  in  32  faulting/restart PC
- exc_bd  in  1  faulting instruction in delay slot
- exc_badvaddr_we  in  1  update BadVAddr
- exc_badvaddr  in  32  faulting address
- status  out  32  current Status
- cause  out  32  current Cause
- epc  out  32  current EPC
- errorepc  out  32  current ErrorEPC
- int_pending  out  1  interrupt request to pipeline

Behaviour:
- Implemented registers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config, 17 LLAddr, 30 ErrorEPC. Other numbers read 0 and ignore writes.
- Reset values:
  - Status = 32'h00400004 (BEV=1, ERL=1).
  - All others 0, except PRId and Config, which always return their parameter values.
  - Timer divider = 0.
  - int_pending = 0 during and after reset until the conditions below hold.
- Write: one-cycle latency. reg <= (reg & ~wmask) | (wdata & wmask).
- Writable-bit rules:
  - Cause: only IP[1:0] (bits 9:8) are writable.
  - PRId and Config are read-only.
  - BadVAddr is writable only via exception.
- Read: rdata is combinational from the register state. A same-cycle write to raddr is bypassed, so rdata shows the post-write value.
- Timer:
  - The divider counts 0..COUNT_DIV-1. On wrap, Count <= Count+1 (mod 2^32; 32'hFFFFFFFF wraps to 0).
  - A write to Count loads the masked value and clears the divider. No increment happens that cycle.
  - When the incremented Count equals Compare, Cause.TI (bit 30) <= 1.
  - A write to Compare clears TI. If a match occurs in the same cycle, the clear wins.
- Interrupt sampling: each cycle, Cause.IP[7:2] <= hw_int[5:0], with IP7 ORed with TI.
- int_pending = Status.IE & ~Status.EXL & ~Status.ERL & |(Cause.IP[7:0] & Status.IM[7:0]). Combinational from registered state.
- Exception entry (exc_valid=1):
  - Cause.ExcCode <= exc_code.
  - If Status.EXL=0: EPC <= exc_epc and Cause.BD <= exc_bd. If EXL=1, EPC and BD are unchanged.
  - Status.EXL <= 1.
  - BadVAddr <= exc_badvaddr if exc_badvaddr_we.
  - Timer and IP sampling continue.
- Simultaneous exc_valid and we: the exception wins. The whole write is dropped, including Count/Compare side effects.
- ERET/EI/DI arrive as ordinary full-mask Status writes. No special port.
- Reset mid-operation: all state returns to reset values on the next edge, and pending TI is lost.

Decomposition:
- cop0_info package holds:
  - register numbers (REG_COUNT, REG_STATUS, ...);
  - bit indices (IDX_STATUS_IE/EXL/ERL/BEV, IDX_CAUSE_BD/TI, IP and IM ranges, ExcCode range);
  - STATUS_RESET value;
  - writable masks per register;
  - exception code enum.
- Sub-module cop0_timer: divider, Count, Compare, and TI set/clear. Exposes count, compare and ti, and accepts masked write strobes.

Test Plan:
- Reset -> status=32'h00400004, cause=0, epc=0, rdata(15)=32'h00018000, int_pending=0.
- we, waddr=12, wdata=32'h0000FF01, wmask=32'hFFFFFFFF, then hw_int=6'b000001 -> status=32'h0000FF01 next cycle; cause[10]=1 and int_pending=1 a cycle later.
- Write Count=32'hFFFFFFFE, Compare=0, COUNT_DIV=2 -> Count reads FFFFFFFF after 2 cycles and 0 after 4; TI=1 on the wrap-to-0 match. A Compare write then clears TI and drops int_pending.
- exc_valid, exc_code=4, exc_epc=32'hBFC00100, exc_bd=1, badvaddr_we, addr=32'h00000003 -> EPC=BFC00100, Cause[6:2]=4, Cause[31]=1, EXL=1, BadVAddr=3. A second exception with epc=32'h80000080 leaves EPC unchanged.
- Same-cycle we to EPC (wdata=32'h12345678) and exc_valid with exc_epc=32'hAAAA0000 -> EPC=AAAA0000, and the write is dropped.
- Cause write wdata=32'hFFFFFFFF, wmask=32'h0000FF00 -> only bits 9:8 change; reading raddr=13 in the same cycle returns the bypassed value.
